fc_argmax: RTL

Classifier output stage directly downstream of fc_layer. Captures the NUM_CLASSES signed FC scores in one cycle when they are presented as valid. Scans them sequentially, one class per cycle, to find the predicted class, the top score and the margin over the runner-up. The single-comparator sequential scan keeps area small; results go to the top-level result register and LED/UART reporting.

---
 rtl/fc_argmax.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/fc_argmax.sv
// fc_argmax: classifier output stage. It captures one vector of signed FC scores
// and then scans it one class per cycle with a single comparator. The scan keeps
// the best score and the runner-up, and reports the winning class index, the top
// score and its margin over the runner-up.
module fc_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 54,
  parameter int IDX_W       = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       fc_valid,
  input  logic signed [NUM_CLASSES-1:0][DATA_W-1:0]  fc_outputs,
  output logic                                       in_ready,
  output logic                                       busy,
  output logic                                       result_valid,
  output logic        [IDX_W-1:0]                    class_idx,
  output logic signed [DATA_W-1:0]                   max_score,
  output logic        [DATA_W:0]                     margin,
  output logic                                       drop_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Most-negative score: the runner-up starts here so any real score beats it.
  localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};
  // Index of the final class; reaching it closes the scan.
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W:0]           NUM_EXT  = (IDX_W+1)'(NUM_CLASSES);

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  score_q [NUM_CLASSES];
  logic signed [DATA_W-1:0]  score_d [NUM_CLASSES];
  logic signed [DATA_W-1:0]  best_q, best_d;
  logic signed [DATA_W-1:0]  second_q, second_d;
  logic        [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic        [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      result_valid_q, result_valid_d;
  logic        [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0]  max_score_q, max_score_d;
  logic        [DATA_W:0]    margin_q, margin_d;
  logic                      drop_err_q, drop_err_d;

  logic signed [DATA_W-1:0]  cur_s;
  logic        [DATA_W:0]    best_ext_s;
  logic        [DATA_W:0]    second_ext_s;

  // Select the captured score at the current scan index (one-hot OR mux).
  always_comb begin
    cur_s = {DATA_W{1'b0}};
    for (int j = 0; j < NUM_CLASSES; j++) begin
      cur_s = cur_s | ((scan_idx_q == IDX_W'(j)) ? score_q[j] : {DATA_W{1'b0}});
    end
  end

  // Next-state, scan datapath and result computation.
  always_comb begin
    state_d        = state_q;
    score_d        = score_q;
    best_d         = best_q;
    second_d       = second_q;
    best_idx_d     = best_idx_q;
    scan_idx_d     = scan_idx_q;
    result_valid_d = 1'b0;
    class_idx_d    = class_idx_q;
    max_score_d    = max_score_q;
    margin_d       = margin_q;
    drop_err_d     = drop_err_q;
    best_ext_s     = {(DATA_W+1){1'b0}};
    second_ext_s   = {(DATA_W+1){1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (fc_valid) begin
          for (int j = 0; j < NUM_CLASSES; j++) begin
            score_d[j] = $signed(fc_outputs[j]);
          end
          best_d     = $signed(fc_outputs[0]);
          best_idx_d = {IDX_W{1'b0}};
          second_d   = MIN_VAL;
          scan_idx_d = IDX_W'(1);
          state_d    = ST_SCAN;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_SCAN: begin
        // With a single class the index already points past the array, so nothing is compared.
        if ({1'b0, scan_idx_q} < NUM_EXT) begin
          // Strict compares: on a tie the earlier index keeps the win.
          if (cur_s > best_q) begin
            second_d   = best_q;
            best_d     = cur_s;
            best_idx_d = scan_idx_q;
          end else if (cur_s > second_q) begin
            second_d   = cur_s;
          end else begin
            second_d   = second_q;
          end
        end else begin
          second_d = second_q;
        end
        scan_idx_d = scan_idx_q + IDX_W'(1);

        if (scan_idx_q >= LAST_IDX) begin
          // The subtraction is one bit wider than a score, so best minus second cannot overflow.
          best_ext_s     = {best_d[DATA_W-1], best_d};
          second_ext_s   = {second_d[DATA_W-1], second_d};
          margin_d       = best_ext_s - second_ext_s;
          class_idx_d    = best_idx_d;
          max_score_d    = best_d;
          result_valid_d = 1'b1;
          state_d        = ST_DONE;
        end else begin
          state_d        = ST_SCAN;
        end

        if (fc_valid) begin
          drop_err_d = 1'b1;
        end else begin
          drop_err_d = drop_err_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (fc_valid) begin
          drop_err_d = 1'b1;
        end else begin
          drop_err_d = drop_err_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_SCAN) || (state_d == ST_DONE);
  end

  // State, capture and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      for (int j = 0; j < NUM_CLASSES; j++) begin
        score_q[j] <= {DATA_W{1'b0}};
      end
      best_q         <= {DATA_W{1'b0}};
      second_q       <= {DATA_W{1'b0}};
      best_idx_q     <= {IDX_W{1'b0}};
      scan_idx_q     <= {IDX_W{1'b0}};
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      class_idx_q    <= {IDX_W{1'b0}};
      max_score_q    <= {DATA_W{1'b0}};
      margin_q       <= {(DATA_W+1){1'b0}};
      drop_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      score_q        <= score_d;
      best_q         <= best_d;
      second_q       <= second_d;
      best_idx_q     <= best_idx_d;
      scan_idx_q     <= scan_idx_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      class_idx_q    <= class_idx_d;
      max_score_q    <= max_score_d;
      margin_q       <= margin_d;
      drop_err_q     <= drop_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign class_idx    = class_idx_q;
  assign max_score    = max_score_q;
  assign margin       = margin_q;
  assign drop_err     = drop_err_q;

endmodule
